// File: rtl/trdb_pkg.sv
// Shared types, register map and reset constants for the trace controller.
package trdb_pkg;

  localparam int unsigned APB_AW  = 4;
  localparam int unsigned APB_DW  = 32;
  localparam int unsigned DRAIN_W = 8;
  localparam int unsigned OVF_BIT = 8;

  typedef enum logic [1:0] {
    TRDB_OFF     = 2'd0,
    TRDB_IDLE    = 2'd1,
    TRDB_TRACING = 2'd2,
    TRDB_DRAIN   = 2'd3
  } trdb_ctrl_state_e;

  typedef enum logic [1:0] {
    FULL_ADDRESS  = 2'd0,
    DELTA_ADDRESS = 2'd1
  } ioptions_e;

  // CTRL register layout; sw_start/sw_stop are write-one pulses
  typedef struct packed {
    logic sw_stop;
    logic sw_start;
    logic notime;
    logic nocontext;
    logic activate;
  } trdb_ctrl_t;

  localparam int unsigned CTRL_W = $bits(trdb_ctrl_t);

  localparam logic [APB_AW-1:0] TRDB_CTRL_OFFSET   = 4'h0;
  localparam logic [APB_AW-1:0] TRDB_STATUS_OFFSET = 4'h4;
  localparam logic [APB_AW-1:0] TRDB_DRAIN_OFFSET  = 4'h8;

  localparam logic [DRAIN_W-1:0] TRDB_DRAIN_RST = 8'd16;

  localparam trdb_ctrl_t TRDB_CTRL_RST = '{
    sw_stop:   1'b0,
    sw_start:  1'b0,
    notime:    1'b1,
    nocontext: 1'b1,
    activate:  1'b0
  };

  // True for the three implemented register offsets
  function automatic logic trdb_addr_valid(input logic [APB_AW-1:0] addr);
    return (addr == TRDB_CTRL_OFFSET) || (addr == TRDB_STATUS_OFFSET) ||
           (addr == TRDB_DRAIN_OFFSET);
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Registered single-edge detector: one-cycle pulse the cycle after the edge.
module edge_detect #(
  parameter bit Falling = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic edge_o
);

  logic d_q;

  // Input history and registered edge pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      d_q    <= 1'b0;
      edge_o <= 1'b0;
    end else begin
      d_q    <= d_i;
      edge_o <= Falling ? (d_q & ~d_i) : (d_i & ~d_q);
    end
  end

endmodule

// File: rtl/trdb_trace_ctrl.sv
// Trace controller: APB register block plus trace on/off/drain sequencing.
module trdb_trace_ctrl
  import trdb_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              psel_i,
  input  logic              penable_i,
  input  logic              pwrite_i,
  input  logic [APB_AW-1:0] paddr_i,
  input  logic [APB_DW-1:0] pwdata_i,
  output logic [APB_DW-1:0] prdata_o,
  output logic              pready_o,
  output logic              pslverr_o,
  input  logic              trace_req_on_i,
  input  logic              trace_req_off_i,
  input  logic              encapsulator_ready_i,
  input  logic              encoder_idle_i,
  output logic              trace_enable_o,
  output logic              trace_activated_o,
  output logic              flush_o,
  output logic              nocontext_o,
  output logic              notime_o,
  output logic              delta_address_o,
  output ioptions_e         configuration_o,
  output logic [1:0]        state_o
);

  trdb_ctrl_state_e   state_q;
  trdb_ctrl_t         ctrl_q;
  logic [DRAIN_W-1:0] drain_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic               overflow_q;
  logic               trace_enable_q;
  logic               trace_activated_q;
  logic               flush_q;

  logic apb_access, addr_valid, reg_we;
  logic wr_ctrl, wr_status, wr_drain;
  logic req_on_rise, req_off_rise, ready_fall;
  logic start_ev, stop_ev, overflow_set;
  logic unused_pwdata;

  assign apb_access = psel_i & penable_i;
  assign addr_valid = trdb_addr_valid(paddr_i);
  assign reg_we     = apb_access & pwrite_i & addr_valid;
  assign wr_ctrl    = reg_we & (paddr_i == TRDB_CTRL_OFFSET);
  assign wr_status  = reg_we & (paddr_i == TRDB_STATUS_OFFSET);
  assign wr_drain   = reg_we & (paddr_i == TRDB_DRAIN_OFFSET);

  assign unused_pwdata = ^pwdata_i[APB_DW-1:OVF_BIT+1];

  edge_detect #(.Falling(1'b0)) u_req_on_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (trace_req_on_i),
    .edge_o (req_on_rise)
  );

  edge_detect #(.Falling(1'b0)) u_req_off_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (trace_req_off_i),
    .edge_o (req_off_rise)
  );

  edge_detect #(.Falling(1'b1)) u_ready_edge (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (encapsulator_ready_i),
    .edge_o (ready_fall)
  );

  // Losing the encapsulator mid-trace is the only stop that flags overflow
  assign start_ev     = req_on_rise | ctrl_q.sw_start;
  assign stop_ev      = req_off_rise | ctrl_q.sw_stop | ready_fall;
  assign overflow_set = (state_q == TRDB_TRACING) & ctrl_q.activate & ready_fall;

  // Register writes; a new overflow beats a simultaneous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_q     <= TRDB_CTRL_RST;
      drain_q    <= TRDB_DRAIN_RST;
      overflow_q <= 1'b0;
    end else begin
      ctrl_q.sw_start <= 1'b0;
      ctrl_q.sw_stop  <= 1'b0;
      if (wr_ctrl) begin
        ctrl_q <= trdb_ctrl_t'(pwdata_i[CTRL_W-1:0]);
      end
      if (wr_drain) begin
        drain_q <= pwdata_i[DRAIN_W-1:0];
      end
      if (overflow_set) begin
        overflow_q <= 1'b1;
      end else if (wr_status && pwdata_i[OVF_BIT]) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // Zero-wait read mux and error response in the access cycle
  always_comb begin
    prdata_o  = '0;
    pslverr_o = 1'b0;
    if (apb_access) begin
      if (!addr_valid) begin
        pslverr_o = 1'b1;
      end else if (!pwrite_i) begin
        case (paddr_i)
          TRDB_CTRL_OFFSET:
            prdata_o = APB_DW'({ctrl_q.notime, ctrl_q.nocontext, ctrl_q.activate});
          TRDB_STATUS_OFFSET:
            prdata_o = APB_DW'({overflow_q, 6'b0, state_q});
          TRDB_DRAIN_OFFSET:
            prdata_o = APB_DW'(drain_q);
          default:
            prdata_o = '0;
        endcase
      end
    end
  end

  // Trace state machine; deactivation overrides every other transition
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q           <= TRDB_OFF;
      trace_enable_q    <= 1'b0;
      trace_activated_q <= 1'b0;
      flush_q           <= 1'b0;
      drain_cnt_q       <= '0;
    end else begin
      flush_q <= 1'b0;
      if (!ctrl_q.activate) begin
        state_q           <= TRDB_OFF;
        trace_enable_q    <= 1'b0;
        trace_activated_q <= 1'b0;
      end else begin
        case (state_q)
          TRDB_OFF: begin
            state_q           <= TRDB_IDLE;
            trace_activated_q <= 1'b1;
          end
          TRDB_IDLE: begin
            if (start_ev && !stop_ev && encapsulator_ready_i) begin
              state_q        <= TRDB_TRACING;
              trace_enable_q <= 1'b1;
            end
          end
          TRDB_TRACING: begin
            if (stop_ev) begin
              state_q        <= TRDB_DRAIN;
              trace_enable_q <= 1'b0;
              flush_q        <= 1'b1;
              drain_cnt_q    <= '0;
            end
          end
          TRDB_DRAIN: begin
            if (encoder_idle_i || (drain_cnt_q == drain_q)) begin
              state_q <= TRDB_IDLE;
            end else if (drain_cnt_q != '1) begin
              drain_cnt_q <= drain_cnt_q + DRAIN_W'(1);
            end
          end
          default: state_q <= TRDB_OFF;
        endcase
      end
    end
  end

  assign pready_o          = 1'b1;
  assign state_o           = state_q;
  assign trace_enable_o    = trace_enable_q;
  assign trace_activated_o = trace_activated_q;
  assign flush_o           = flush_q;
  assign nocontext_o       = ctrl_q.nocontext;
  assign notime_o          = ctrl_q.notime;
  assign delta_address_o   = 1'b1;
  assign configuration_o   = DELTA_ADDRESS;

endmodule

// File: tb/tb_trdb_trace_ctrl.sv
// Bench for trdb_trace_ctrl: directed scenarios plus randomized traffic vs a reference model.
module tb_trdb_trace_ctrl;
  import trdb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        psel_i = 1'b0, penable_i = 1'b0, pwrite_i = 1'b0;
  logic [3:0]  paddr_i = '0;
  logic [31:0] pwdata_i = '0;
  logic [31:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic        trace_req_on_i = 1'b0, trace_req_off_i = 1'b0;
  logic        encapsulator_ready_i = 1'b0, encoder_idle_i = 1'b0;
  logic        trace_enable_o, trace_activated_o, flush_o;
  logic        nocontext_o, notime_o, delta_address_o;
  ioptions_e   configuration_o;
  logic [1:0]  state_o;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: current state, register shadows, pending events
  int m_state, m_drain, m_dcyc;
  bit m_en, m_flush, m_ovf, m_act, m_noctx, m_notime;
  bit h_on, h_off, h_rdy, p_start, p_stop, p_ovf;

  trdb_trace_ctrl dut (
    .clk_i                (clk_i),
    .rst_ni               (rst_ni),
    .psel_i               (psel_i),
    .penable_i            (penable_i),
    .pwrite_i             (pwrite_i),
    .paddr_i              (paddr_i),
    .pwdata_i             (pwdata_i),
    .prdata_o             (prdata_o),
    .pready_o             (pready_o),
    .pslverr_o            (pslverr_o),
    .trace_req_on_i       (trace_req_on_i),
    .trace_req_off_i      (trace_req_off_i),
    .encapsulator_ready_i (encapsulator_ready_i),
    .encoder_idle_i       (encoder_idle_i),
    .trace_enable_o       (trace_enable_o),
    .trace_activated_o    (trace_activated_o),
    .flush_o              (flush_o),
    .nocontext_o          (nocontext_o),
    .notime_o             (notime_o),
    .delta_address_o      (delta_address_o),
    .configuration_o      (configuration_o),
    .state_o              (state_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, want);
  endtask

  function automatic void model_reset();
    m_state = 0; m_drain = 16; m_dcyc = 0;
    m_en = 0; m_flush = 0; m_ovf = 0; m_act = 0; m_noctx = 1; m_notime = 1;
    h_on = 0; h_off = 0; h_rdy = 0; p_start = 0; p_stop = 0; p_ovf = 0;
  endfunction

  function automatic bit addr_err(input logic [3:0] a);
    return !(a == 4'h0 || a == 4'h4 || a == 4'h8);
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] a);
    case (a)
      4'h0:    return {29'b0, m_notime, m_noctx, m_act};
      4'h4:    return {23'b0, m_ovf, 6'b0, 2'(m_state)};
      4'h8:    return 32'(m_drain);
      default: return 32'h0;
    endcase
  endfunction

  // One clock edge of the specified behaviour, from the inputs present at that edge
  function automatic void model_tick();
    bit wr, ovf_set;
    int ns, age;
    wr = psel_i && penable_i && pwrite_i;
    ns = m_state;
    ovf_set = 0;
    if (!m_act) ns = 0;
    else begin
      case (m_state)
        0: ns = 1;
        1: if (p_start && !p_stop && encapsulator_ready_i) ns = 2;
        2: if (p_stop) begin ns = 3; ovf_set = p_ovf; end
        default: begin
          age = (m_dcyc - 1 > 255) ? 255 : m_dcyc - 1;
          if (encoder_idle_i || age == m_drain) ns = 1;
        end
      endcase
    end
    if (ovf_set) m_ovf = 1;
    else if (wr && paddr_i == 4'h4 && pwdata_i[8]) m_ovf = 0;
    m_flush = (ns == 3) && (m_state != 3);
    if (m_flush) m_dcyc = 1;
    else if (ns == 3) m_dcyc++;
    m_en = (ns == 2);
    m_state = ns;
    p_start = (trace_req_on_i && !h_on) || (wr && paddr_i == 4'h0 && pwdata_i[3]);
    p_stop  = (trace_req_off_i && !h_off) || (wr && paddr_i == 4'h0 && pwdata_i[4]) ||
              (!encapsulator_ready_i && h_rdy);
    p_ovf   = !encapsulator_ready_i && h_rdy;
    h_on = trace_req_on_i; h_off = trace_req_off_i; h_rdy = encapsulator_ready_i;
    if (wr && paddr_i == 4'h0) begin
      m_act = pwdata_i[0]; m_noctx = pwdata_i[1]; m_notime = pwdata_i[2];
    end
    if (wr && paddr_i == 4'h8) m_drain = int'(pwdata_i[7:0]);
  endfunction

  task automatic check_outs();
    logic [10:0] obs, want;
    obs  = {state_o, trace_enable_o, flush_o, trace_activated_o, nocontext_o, notime_o,
            delta_address_o, 2'(configuration_o), pready_o};
    want = {2'(m_state), m_en, m_flush, m_state != 0, m_noctx, m_notime,
            1'b1, 2'(DELTA_ADDRESS), 1'b1};
    chk("outs", 32'(obs), 32'(want));
  endtask

  task automatic step();
    @(posedge clk_i);
    if (!rst_ni) model_reset();
    else model_tick();
    @(negedge clk_i);
    check_outs();
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    psel_i = 1; penable_i = 0; pwrite_i = 1; paddr_i = a; pwdata_i = d;
    step();
    penable_i = 1;
    #1;
    chk("wr_pslverr", 32'(pslverr_o), 32'(addr_err(a)));
    step();
    psel_i = 0; penable_i = 0; pwrite_i = 0;
  endtask

  task automatic apb_read(input logic [3:0] a, input logic [31:0] want, input bit use_model,
                          input string tag);
    psel_i = 1; penable_i = 0; pwrite_i = 0; paddr_i = a;
    step();
    penable_i = 1;
    #1;
    chk({tag, "_err"}, 32'(pslverr_o), 32'(addr_err(a)));
    chk(tag, prdata_o, use_model ? model_read(a) : want);
    step();
    psel_i = 0; penable_i = 0;
  endtask

  task automatic start_trace();
    trace_req_on_i = 1; step();
    trace_req_on_i = 0; step();
  endtask

  task automatic count_drain(input int want, input string tag);
    int n;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (state_o == 2'd3) n++;
      else if (n > 0) break;
    end
    chk(tag, 32'(n), 32'(want));
    chk({tag, "_exit"}, 32'(state_o), 32'd1);
  endtask

  task automatic random_apb();
    int k;
    logic [3:0] a;
    k = $urandom_range(0, 5);
    case (k)
      0: apb_write(4'h0, {27'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 7) != 0)});
      1: apb_write(4'h4, $urandom);
      2: apb_write(4'h8, 32'($urandom_range(0, 6)));
      default: begin
        a = 4'(4 * (k - 3));
        apb_read(a, 32'h0, 1'b1, "rand_read");
      end
    endcase
  endtask

  initial begin
    model_reset();
    #12;
    check_outs();
    chk("rst_prdata", prdata_o, 32'h0);
    chk("rst_pslverr", 32'(pslverr_o), 32'h0);
    chk("rst_enable", 32'(trace_enable_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1;

    apb_read(4'h0, 32'h6, 1'b0, "rst_ctrl");
    apb_read(4'h8, 32'd16, 1'b0, "rst_drain");
    apb_read(4'h4, 32'h0, 1'b0, "rst_status");

    // Activation and hardware start, two-cycle enable latency
    encapsulator_ready_i = 1;
    step();
    apb_write(4'h0, 32'h7);
    step();
    chk("idle_after_activate", 32'(state_o), 32'd1);
    trace_req_on_i = 1; step();
    chk("enable_1cyc", 32'(trace_enable_o), 32'd0);
    trace_req_on_i = 0; step();
    chk("enable_2cyc", 32'(trace_enable_o), 32'd1);
    chk("tracing", 32'(state_o), 32'd2);

    // Encapsulator loss: drain, one flush, overflow sticky, W1C
    encapsulator_ready_i = 0; step();
    chk("still_tracing", 32'(state_o), 32'd2);
    step();
    chk("flush_on", 32'(flush_o), 32'd1);
    chk("drain_entry", 32'(state_o), 32'd3);
    step();
    chk("flush_off", 32'(flush_o), 32'd0);
    apb_read(4'h4, 32'h103, 1'b0, "status_ovf");
    apb_write(4'h4, 32'h100);
    encapsulator_ready_i = 1; encoder_idle_i = 1; step();
    chk("idle_after_drain", 32'(state_o), 32'd1);
    encoder_idle_i = 0;
    apb_read(4'h4, 32'h001, 1'b0, "status_cleared");

    // Drain timeout lengths
    apb_write(4'h8, 32'd3);
    start_trace();
    apb_write(4'h0, 32'h17);
    count_drain(4, "drain3_cycles");
    apb_write(4'h8, 32'd0);
    start_trace();
    apb_write(4'h0, 32'h17);
    count_drain(1, "drain0_cycles");

    // Simultaneous start and stop in IDLE
    trace_req_on_i = 1; trace_req_off_i = 1; step();
    trace_req_on_i = 0; trace_req_off_i = 0; step(); step();
    chk("stopwins_state", 32'(state_o), 32'd1);
    chk("stopwins_enable", 32'(trace_enable_o), 32'd0);

    // Unmapped access and deactivation while tracing
    apb_read(4'hC, 32'h0, 1'b0, "unmapped_read");
    apb_write(4'hC, 32'h0);
    apb_read(4'h0, 32'h7, 1'b0, "ctrl_after_unmapped");
    start_trace();
    chk("tracing_again", 32'(state_o), 32'd2);
    apb_write(4'h0, 32'h6);
    chk("off_not_yet", 32'(state_o), 32'd2);
    step();
    chk("off_state", 32'(state_o), 32'd0);
    chk("off_enable", 32'(trace_enable_o), 32'd0);

    // Randomized traffic against the model
    apb_write(4'h0, 32'h7);
    step();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) trace_req_on_i = ~trace_req_on_i;
      if ($urandom_range(0, 7) == 0) trace_req_off_i = ~trace_req_off_i;
      encapsulator_ready_i = ($urandom_range(0, 15) != 0);
      encoder_idle_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) random_apb();
      else step();
    end

    // Asynchronous reset in the first DRAIN cycle
    trace_req_on_i = 0; trace_req_off_i = 0; encapsulator_ready_i = 1; encoder_idle_i = 0;
    apb_write(4'h0, 32'h6);
    step(); step();
    apb_write(4'h8, 32'd255);
    apb_write(4'h0, 32'h7);
    step();
    apb_write(4'h0, 32'hF);
    step();
    chk("pre_rst_tracing", 32'(state_o), 32'd2);
    apb_write(4'h0, 32'h17);
    step();
    chk("pre_rst_flush", 32'(flush_o), 32'd1);
    #2;
    rst_ni = 0;
    #1;
    model_reset();
    check_outs();
    chk("arst_flush", 32'(flush_o), 32'd0);
    chk("arst_enable", 32'(trace_enable_o), 32'd0);
    chk("arst_state", 32'(state_o), 32'd0);
    chk("arst_prdata", prdata_o, 32'h0);
    step(); step();
    @(negedge clk_i);
    rst_ni = 1;
    step();
    apb_read(4'h0, 32'h6, 1'b0, "post_rst_ctrl");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/trdb_trace_ctrl.md
TRDB_TRACE_CTRL -- requirements
Module: trdb_trace_ctrl

Interface
REQ-001 SHALL have clk_i  in  1  clock; rst_ni  in  1  reset, asynchronous, active-low.
REQ-002 SHALL have APB slave: psel_i, penable_i, pwrite_i  in  1 each; paddr_i  in  4  byte address; pwdata_i  in  32; prdata_o  out  32; pready_o  out  1; pslverr_o  out  1.
REQ-003 SHALL have trace_req_on_i  in  1  trigger start level; trace_req_off_i  in  1  filter stop level.
REQ-004 SHALL have encapsulator_ready_i  in  1  downstream can accept; encoder_idle_i  in  1  no packet pending.
REQ-005 SHALL have trace_enable_o  out  1; trace_activated_o  out  1; flush_o  out  1  one-cycle drain request; nocontext_o, notime_o, delta_address_o  out  1 each; configuration_o  out  ioptions_e; state_o  out  2.

Function
REQ-006 Registers SHALL be: CTRL 0x0 RW (bit0 activate, bit1 nocontext, bit2 notime, bit3 sw_start W1-pulse, bit4 sw_stop W1-pulse, reads 0 for bits 3-4); STATUS 0x4 (bits1:0 state RO, bit8 overflow sticky, W1C); DRAIN 0x8 RW bits7:0 drain timeout.
REQ-007 APB SHALL be zero-wait: pready_o=1 always; access completes in the psel&penable cycle; write takes effect next cycle.
REQ-008 Unmapped paddr_i SHALL give pslverr_o=1 in the access cycle, prdata_o=0, no state change.
REQ-009 FSM states SHALL be OFF(0), IDLE(1), TRACING(2), DRAIN(3); state_o reflects current state.
REQ-010 OFF->IDLE when CTRL.activate=1; any state->OFF one cycle after activate cleared, overriding all other transitions.
REQ-011 IDLE->TRACING on (rising edge of trace_req_on_i OR sw_start) AND encapsulator_ready_i=1; otherwise stay IDLE.
REQ-012 TRACING->DRAIN on rising edge of trace_req_off_i, sw_stop, or falling edge of encapsulator_ready_i; the last also sets STATUS.overflow.
REQ-013 Simultaneous start and stop events SHALL resolve stop-wins: IDLE stays IDLE; TRACING goes DRAIN.
REQ-014 Start events in TRACING/DRAIN and stop events in IDLE/OFF SHALL be ignored (not queued).
REQ-015 On DRAIN entry, flush_o=1 for exactly one cycle and 8-bit drain counter loads 0.
REQ-016 DRAIN->IDLE when encoder_idle_i=1 or counter == DRAIN value; counter increments per DRAIN cycle, saturating at 255; DRAIN=0 exits after one cycle.
REQ-017 trace_enable_o SHALL be registered, =1 iff state==TRACING; latency edge-on-input to trace_enable_o=1 is 2 cycles (edge detect register + state register).
REQ-018 trace_activated_o=1 iff state!=OFF.
REQ-019 nocontext_o/notime_o SHALL mirror CTRL bits; delta_address_o=1 and configuration_o=DELTA_ADDRESS constant.
REQ-020 Overflow set and W1C in same cycle: set wins.

Reset
REQ-021 On reset: state OFF, trace_enable_o=0, trace_activated_o=0, flush_o=0, CTRL=0x6 (nocontext=1, notime=1), DRAIN=16, overflow=0, edge-detect history=0, prdata_o=0, pslverr_o=0.
REQ-022 Reset mid-TRACING/DRAIN SHALL drop trace_enable_o and flush_o immediately (asynchronous).

Structure
REQ-023 Package trdb_pkg SHALL hold state enum trdb_ctrl_state_e, register offsets, DRAIN reset constant 16, and existing ioptions_e.
REQ-024 Edge detection SHALL reuse sub-module edge_detect (three instances: req_on, req_off, encapsulator_ready), clocked on clk_i.

Verification
REQ-025 Write CTRL=0x7, pulse trace_req_on_i with ready=1 -> state 1 then 2, trace_enable_o=1 two cycles after edge.
REQ-026 In TRACING drop encapsulator_ready_i -> DRAIN, flush_o one cycle, STATUS reads 0x103; W1C 0x100 -> reads 0x001 after drain.
REQ-027 DRAIN=3, encoder_idle_i=0 -> DRAIN lasts 4 cycles then IDLE; DRAIN=0 -> 1 cycle.
REQ-028 In IDLE assert req_on and req_off same cycle -> stays IDLE, trace_enable_o=0.
REQ-029 Read paddr 0xC -> pslverr_o=1, prdata_o=0; clear activate while TRACING -> OFF next cycle, trace_enable_o=0.
REQ-030 Assert rst_ni low during DRAIN -> all outputs at reset values without clock edge.
